// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_FULL  = 2'd2,
        S_DRAIN = 2'd3
    } ifetch_state_t;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;
    localparam int          PERF_CNT_W       = 32;

    // A memory request is on the bus in these states.
    function automatic logic req_active(input ifetch_state_t st);
        return (st == S_REQ) || (st == S_DRAIN);
    endfunction

endpackage

// File: rtl/ifetch_skid.sv
// One-entry {inst, pc} holding buffer used when a response lands while
// the IF/ID stage is stalled. Clear has priority over load and unload.
module ifetch_skid #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              unload_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    // Next-state of the entry: clear, else load, else unload, else hold.
    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            inst_d  = inst_i;
            pc_d    = pc_i;
        end else if (unload_i) begin
            valid_d = 1'b0;
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch-side controller: issues imem requests at the current PC, advances
// the PC on every accepted response, feeds the IF/ID register through a
// one-entry skid buffer and drops in-flight responses on a branch flush.
// Optional build macro IFETCH_PERF_CNT_EN adds fetch/wait/flush counters.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEFAULT)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_W-1:0]     pc_i,
    output logic                  pc_write_o,
    input  logic                  flush_i,
    input  logic                  id_stall_i,
    output logic                  imem_req_o,
    output logic [ADDR_W-1:0]     imem_addr_o,
    input  logic                  imem_ack_i,
    input  logic [DATA_W-1:0]     imem_rdata_i,
    output logic [DATA_W-1:0]     inst_o,
    output logic [ADDR_W-1:0]     inst_pc_o,
    output logic                  inst_valid_o
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_fetch_o,
    output logic [PERF_CNT_W-1:0] perf_wait_o,
    output logic [PERF_CNT_W-1:0] perf_flush_o
`endif
);

    ifetch_state_t     state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;

    logic              req_c;
    logic              pc_write_c;
    logic              skid_load, skid_unload, skid_clear;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_inst;
    logic [ADDR_W-1:0] skid_pc;

    ifetch_skid #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .inst_i   (imem_rdata_i),
        .pc_i     (pc_i),
        .valid_o  (skid_valid),
        .inst_o   (skid_inst),
        .pc_o     (skid_pc)
    );

    // Next state, IF/ID register update, skid control and handshake outputs.
    // While in S_REQ the PC cannot move (it only moves on ack or flush), so
    // pc_i is the request address; req_addr_q keeps it for the drain.
    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        skid_load    = 1'b0;
        skid_unload  = 1'b0;
        skid_clear   = 1'b0;
        req_c        = req_active(state_q);
        pc_write_c   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                req_addr_d = pc_i;
                if (imem_ack_i) begin
                    pc_write_c = 1'b1;
                    if (id_stall_i) begin
                        skid_load = 1'b1;
                        state_d   = S_FULL;
                    end else begin
                        inst_d       = imem_rdata_i;
                        inst_pc_d    = pc_i;
                        inst_valid_d = 1'b1;
                    end
                end else if (!id_stall_i) begin
                    // ID consumed the current entry and nothing new arrived.
                    inst_d       = NOP_INST;
                    inst_valid_d = 1'b0;
                end
            end
            S_FULL: begin
                if (!id_stall_i) begin
                    inst_d       = skid_inst;
                    inst_pc_d    = skid_pc;
                    inst_valid_d = skid_valid;
                    skid_unload  = 1'b1;
                    state_d      = S_REQ;
                end
            end
            S_DRAIN: begin
                // Stale response: wait for it, never advance the PC.
                if (imem_ack_i) begin
                    state_d = S_REQ;
                end
                if (!id_stall_i) begin
                    inst_d       = NOP_INST;
                    inst_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush overrides everything above, including a stall or an ack.
        if (flush_i) begin
            pc_write_c   = 1'b1;
            skid_load    = 1'b0;
            skid_unload  = 1'b0;
            skid_clear   = 1'b1;
            inst_d       = NOP_INST;
            inst_pc_d    = inst_pc_q;
            inst_valid_d = 1'b0;
            state_d      = (req_c && !imem_ack_i) ? S_DRAIN : S_REQ;
        end
    end

    // State, request address and IF/ID register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            req_addr_q   <= '0;
            inst_q       <= NOP_INST;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // Reset drops the request and blocks PC writes immediately.
    assign imem_req_o   = req_c & ~rst_i;
    assign pc_write_o   = pc_write_c & ~rst_i;
    assign imem_addr_o  = (state_q == S_REQ) ? pc_i : req_addr_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = inst_valid_q;

`ifdef IFETCH_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] perf_fetch_q, perf_fetch_d;
    logic [PERF_CNT_W-1:0] perf_wait_q, perf_wait_d;
    logic [PERF_CNT_W-1:0] perf_flush_q, perf_flush_d;

    // Event counters; wrap naturally at 2^PERF_CNT_W.
    always_comb begin
        perf_fetch_d = perf_fetch_q
                     + PERF_CNT_W'((state_q == S_REQ) && imem_ack_i && !flush_i);
        perf_wait_d  = perf_wait_q
                     + PERF_CNT_W'((state_q == S_REQ) && !imem_ack_i);
        perf_flush_d = perf_flush_q + PERF_CNT_W'(flush_i);
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_fetch_q <= '0;
            perf_wait_q  <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_wait_q  <= perf_wait_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_wait_o  = perf_wait_q;
    assign perf_flush_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed cycle table, hand-written flush/reset
// sequences, then randomized traffic against a PC-queue reference model.
module tb_ifetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_write_o;
    logic        flush;
    logic        stall;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetch, perf_wait, perf_flush;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ifetch_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .pc_i         (pc_in),
        .pc_write_o   (pc_write_o),
        .flush_i      (flush),
        .id_stall_i   (stall),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (ack),
        .imem_rdata_i (rdata),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetch_o (perf_fetch),
        .perf_wait_o  (perf_wait),
        .perf_flush_o (perf_flush)
`endif
    );

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        fl, st, ack;
        logic [31:0] rd;
        logic        e_pw, e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_inst, e_ipc;
        logic        ipc_chk;
    } vec_t;

    // Instruction memory contents: unique word per address.
    function automatic logic [31:0] W(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic vec_t mk(input logic r, input logic [31:0] pc,
                                input logic fl, input logic st, input logic ak,
                                input logic [31:0] rd, input logic pw, input logic rq,
                                input logic [31:0] addr, input logic vld,
                                input logic [31:0] inst, input logic [31:0] ipc,
                                input logic ipc_chk);
        vec_t v;
        v.rst = r; v.pc = pc; v.fl = fl; v.st = st; v.ack = ak; v.rd = rd;
        v.e_pw = pw; v.e_req = rq; v.e_addr = addr; v.e_vld = vld;
        v.e_inst = inst; v.e_ipc = ipc; v.ipc_chk = ipc_chk;
        return v;
    endfunction

    task automatic chk(input string tag, input string what,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s.%s got=%h expected=%h", tag, what, got, exp);
        end
    endtask

    // Apply one cycle of inputs and compare this cycle's outputs.
    task automatic cyc(input vec_t v, input string tag);
        @(negedge clk);
        rst = v.rst; pc_in = v.pc; flush = v.fl; stall = v.st;
        ack = v.ack; rdata = v.rd;
        #1;
        if (!v.rst) begin
            chk(tag, "pc_write", 32'(pc_write_o), 32'(v.e_pw));
            chk(tag, "req", 32'(imem_req_o), 32'(v.e_req));
            if (v.e_req) chk(tag, "addr", imem_addr_o, v.e_addr);
        end
        chk(tag, "valid", 32'(inst_valid_o), 32'(v.e_vld));
        chk(tag, "inst", inst_o, v.e_vld ? v.e_inst : NOP);
        if (v.e_vld || v.ipc_chk) chk(tag, "inst_pc", inst_pc_o, v.e_ipc);
    endtask

    vec_t        tv[$];
    logic [31:0] q[$];
    logic [31:0] pc_r, tgt;
    logic        discard, acc;
    int          consumed;

    initial begin
        rst = 1'b1; pc_in = '0; flush = 1'b0; stall = 1'b0; ack = 1'b0; rdata = '0;
        repeat (2) @(posedge clk);

        // Zero-wait run, 2-wait fetch at 0x10, response under a 3-cycle stall.
        //             rst pc      fl st ak rd            pw rq addr    v  inst          ipc    ic
        tv.push_back(mk(0, 32'h00, 0, 0, 0, 0,            0, 0, 0,      0, 0,            32'h0, 1));
        tv.push_back(mk(0, 32'h00, 0, 0, 1, W(32'h00),    1, 1, 32'h00, 0, 0,            0,     0));
        tv.push_back(mk(0, 32'h04, 0, 0, 1, W(32'h04),    1, 1, 32'h04, 1, W(32'h00),    32'h00,0));
        tv.push_back(mk(0, 32'h08, 0, 0, 1, W(32'h08),    1, 1, 32'h08, 1, W(32'h04),    32'h04,0));
        tv.push_back(mk(0, 32'h0C, 0, 0, 1, W(32'h0C),    1, 1, 32'h0C, 1, W(32'h08),    32'h08,0));
        tv.push_back(mk(0, 32'h10, 0, 0, 0, 0,            0, 1, 32'h10, 1, W(32'h0C),    32'h0C,0));
        tv.push_back(mk(0, 32'h10, 0, 0, 0, 0,            0, 1, 32'h10, 0, 0,            0,     0));
        tv.push_back(mk(0, 32'h10, 0, 0, 1, 32'h8C020004, 1, 1, 32'h10, 0, 0,            0,     0));
        tv.push_back(mk(0, 32'h14, 0, 0, 1, W(32'h14),    1, 1, 32'h14, 1, 32'h8C020004, 32'h10,0));
        tv.push_back(mk(0, 32'h18, 0, 0, 1, W(32'h18),    1, 1, 32'h18, 1, W(32'h14),    32'h14,0));
        tv.push_back(mk(0, 32'h1C, 0, 0, 1, W(32'h1C),    1, 1, 32'h1C, 1, W(32'h18),    32'h18,0));
        tv.push_back(mk(0, 32'h20, 0, 1, 1, W(32'h20),    1, 1, 32'h20, 1, W(32'h1C),    32'h1C,0));
        tv.push_back(mk(0, 32'h24, 0, 1, 0, 0,            0, 0, 0,      1, W(32'h1C),    32'h1C,0));
        tv.push_back(mk(0, 32'h24, 0, 1, 0, 0,            0, 0, 0,      1, W(32'h1C),    32'h1C,0));
        tv.push_back(mk(0, 32'h24, 0, 0, 0, 0,            0, 0, 0,      1, W(32'h1C),    32'h1C,0));
        tv.push_back(mk(0, 32'h24, 0, 0, 0, 0,            0, 1, 32'h24, 1, W(32'h20),    32'h20,0));
        tv.push_back(mk(0, 32'h24, 0, 0, 1, W(32'h24),    1, 1, 32'h24, 0, 0,            0,     0));
        tv.push_back(mk(0, 32'h28, 0, 0, 0, 0,            0, 1, 32'h28, 1, W(32'h24),    32'h24,0));
        for (int i = 0; i < tv.size(); i++) cyc(tv[i], $sformatf("tbl%0d", i));

        // Flush during a waited request at 0x30, redirect to 0x100: drain.
        cyc(mk(0, 32'h28,  0, 0, 1, W(32'h28),  1, 1, 32'h28,  0, 0,          0,      0), "drn1");
        cyc(mk(0, 32'h2C,  0, 0, 1, W(32'h2C),  1, 1, 32'h2C,  1, W(32'h28),  32'h28, 0), "drn2");
        cyc(mk(0, 32'h30,  0, 0, 0, 0,          0, 1, 32'h30,  1, W(32'h2C),  32'h2C, 0), "drn3");
        cyc(mk(0, 32'h30,  1, 0, 0, 0,          1, 1, 32'h30,  0, 0,          0,      0), "drn4");
        cyc(mk(0, 32'h100, 0, 0, 0, 0,          0, 1, 32'h30,  0, 0,          0,      0), "drn5");
        cyc(mk(0, 32'h100, 0, 0, 0, 0,          0, 1, 32'h30,  0, 0,          0,      0), "drn6");
        cyc(mk(0, 32'h100, 0, 0, 1, W(32'h30),  0, 1, 32'h30,  0, 0,          0,      0), "drn7");
        cyc(mk(0, 32'h100, 0, 0, 0, 0,          0, 1, 32'h100, 0, 0,          0,      0), "drn8");
        cyc(mk(0, 32'h100, 0, 0, 1, W(32'h100), 1, 1, 32'h100, 0, 0,          0,      0), "drn9");

        // Flush coincident with ack and stall, redirect to 0x200.
        cyc(mk(0, 32'h104, 0, 0, 1, W(32'h104), 1, 1, 32'h104, 1, W(32'h100), 32'h100,0), "fa1");
        cyc(mk(0, 32'h108, 1, 1, 1, W(32'h108), 1, 1, 32'h108, 1, W(32'h104), 32'h104,0), "fa2");
        cyc(mk(0, 32'h200, 0, 0, 0, 0,          0, 1, 32'h200, 0, 0,          0,      0), "fa3");
        cyc(mk(0, 32'h200, 0, 0, 1, W(32'h200), 1, 1, 32'h200, 0, 0,          0,      0), "fa4");

        // Reset in the middle of a request, then restart from 0.
        cyc(mk(0, 32'h204, 0, 1, 0, 0,          0, 1, 32'h204, 1, W(32'h200), 32'h200,0), "rs1");
        cyc(mk(1, 32'h204, 0, 0, 0, 0,          0, 0, 0,       1, W(32'h200), 32'h200,0), "rs2");
        cyc(mk(0, 32'h000, 0, 0, 0, 0,          0, 0, 0,       0, 0,          32'h0,  1), "rs3");
        cyc(mk(0, 32'h000, 0, 0, 1, W(32'h0),   1, 1, 32'h0,   0, 0,          0,      0), "rs4");
        cyc(mk(0, 32'h004, 0, 0, 0, 0,          0, 1, 32'h4,   1, W(32'h0),   32'h0,  0), "rs5");

        // Randomized traffic. Model: queue of PCs fetched but not yet
        // consumed by ID, a PC register, and a flag for a stale response.
        @(negedge clk);
        rst = 1'b1; pc_in = '0; flush = 1'b0; stall = 1'b0; ack = 1'b0;
        repeat (2) @(negedge clk);
        pc_r = '0; discard = 1'b0; consumed = 0; q.delete();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst   = 1'b0;
            flush = ($urandom_range(0, 11) == 0);
            stall = ($urandom_range(0, 3) == 0);
            tgt   = 32'($urandom_range(0, 4095)) << 2;
            pc_in = pc_r;
            ack   = 1'b0;
            rdata = '0;
            #1;
            if (imem_req_o) begin
                ack = ($urandom_range(0, 2) != 0);
                if (ack) rdata = W(imem_addr_o);
            end
            #1;
            acc = imem_req_o && ack && !flush && !discard;
            chk("rnd", "pc_write", 32'(pc_write_o), 32'(flush || acc));
            if (discard) chk("rnd", "drain_req", 32'(imem_req_o), 32'd1);
            else if (imem_req_o) chk("rnd", "addr", imem_addr_o, pc_r);
            if (inst_valid_o) begin
                chk("rnd", "spurious_valid", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    chk("rnd", "order_pc", inst_pc_o, q[0]);
                    chk("rnd", "order_inst", inst_o, W(q[0]));
                end
            end else begin
                chk("rnd", "bubble_nop", inst_o, NOP);
            end
            if (flush) begin
                q.delete();
                discard = imem_req_o && !ack;
            end else begin
                if (discard && ack) discard = 1'b0;
                if (inst_valid_o && !stall && q.size() != 0) begin
                    void'(q.pop_front());
                    consumed++;
                end
                if (acc) begin
                    q.push_back(pc_r);
                    chk("rnd", "depth", 32'(q.size() <= 2), 32'd1);
                end
            end
            pc_r = flush ? tgt : (acc ? pc_r + 32'd4 : pc_r);
        end
        chk("rnd", "progress", 32'(consumed >= 300), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
